// File: rtl/ff_pkg.sv
// ff_pkg: definitions shared by the frame-control arithmetic blocks
// (frame-count divider and ff_multiplier).
//   FF_W            : default operand/result width of the frame path
//   FF_MAX          : all-ones position value, used as the saturation result
//   ff_mul_state_t  : multiplier sequencing states
package ff_pkg;

  localparam int FF_W = 12;

  localparam logic [FF_W-1:0] FF_MAX = {FF_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } ff_mul_state_t;

endpackage : ff_pkg

// File: rtl/ff_multiplier.sv
// ff_multiplier: fixed-latency shift-add multiplier that turns a frame index
// and a per-frame step into the frame start position (index * divisor),
// saturated to W bits.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset, overrides everything
//   start    in   request, sampled only while idle
//   index    in   W  multiplicand, captured on acceptance
//   divisor  in   W  multiplier, captured on acceptance
//   busy     out  high from the cycle after acceptance through the done cycle
//   done     out  one-cycle pulse, product/ovf valid from this cycle
//   product  out  W  index*divisor, or all-ones on overflow
//   ovf      out  true product did not fit in W bits
//
// Latency is always W+1 cycles from acceptance to done (no early exit), so
// control logic can rely on a fixed schedule.
module ff_multiplier
  import ff_pkg::*;
#(
  parameter int W = FF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] index,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product,
  output logic         ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  ff_mul_state_t   state_reg,   state_next;
  logic [CW-1:0]   cnt_reg,     cnt_next;
  logic [W-1:0]    idx_reg,     idx_next;
  logic [W-1:0]    div_reg,     div_next;
  logic [2*W-1:0]  acc_reg,     acc_next;
  logic [W-1:0]    product_reg, product_next;
  logic            ovf_reg,     ovf_next;

  // Index zero-extended to the accumulator width and aligned to the
  // divisor bit currently being examined.
  logic [2*W-1:0]  addend;
  logic [2*W-1:0]  acc_step;

  assign addend   = {{W{1'b0}}, idx_reg} << cnt_reg;
  assign acc_step = div_reg[cnt_reg] ? (acc_reg + addend) : acc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      div_reg     <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      div_reg     <= div_next;
      acc_reg     <= acc_next;
      product_reg <= product_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    div_next     = div_reg;
    acc_next     = acc_reg;
    product_next = product_reg;
    ovf_next     = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next   = index;
          div_next   = divisor;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = CALC;
        end
      end

      CALC: begin
        acc_next = acc_step;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STEP) begin
          // Final partial product lands this edge; register the result
          // from the completed sum so it is valid during the done cycle.
          cnt_next     = '0;
          ovf_next     = |acc_step[2*W-1:W];
          product_next = (|acc_step[2*W-1:W]) ? {W{1'b1}} : acc_step[W-1:0];
          state_next   = DONE;
        end
      end

      DONE: begin
        // A start seen here is intentionally dropped: no queueing.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign product = product_reg;
  assign ovf     = ovf_reg;

endmodule : ff_multiplier

// File: tb/tb_ff_multiplier.sv
// tb_ff_multiplier: randomized and directed self-checking bench for
// ff_multiplier, comparing against a plain-arithmetic reference.
module tb_ff_multiplier;

  localparam int W   = 12;
  localparam int LAT = W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] index;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] product;
  logic         ovf;

  int n_checks;
  int n_fail;

  ff_multiplier #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .index   (index),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, saturated to the W-bit range.
  function automatic void ref_mul(input int a, input int b,
                                  output logic [W-1:0] p, output logic o);
    longint full;
    full = longint'(a) * longint'(b);
    o    = (full > ((1 << W) - 1));
    p    = o ? W'((1 << W) - 1) : W'(full);
  endfunction

  // Accept one request, then follow it for LAT+1 cycles checking the busy
  // window, the single done pulse and the result.
  task automatic run_op(input int a, input int b, input string name);
    logic [W-1:0] exp_p;
    logic         exp_o;
    int           busy_bad;
    int           done_cnt;
    int           done_at;
    ref_mul(a, b, exp_p, exp_o);
    @(negedge clk);
    index   = W'(a);
    divisor = W'(b);
    start   = 1'b1;
    busy_bad = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start   = 1'b0;
        index   = W'($urandom);
        divisor = W'($urandom);
      end
      if (busy !== (k <= LAT)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k == LAT) begin
        n_checks++;
        if (product !== exp_p || ovf !== exp_o) begin
          n_fail++;
          $display("FAIL %s result: got product=%0d ovf=%0b, want product=%0d ovf=%0b (%0d*%0d)",
                   name, product, ovf, exp_p, exp_o, a, b);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_at != LAT) begin
      n_fail++;
      $display("FAIL %s done timing: got %0d pulses last at +%0d, want 1 pulse at +%0d",
               name, done_cnt, done_at, LAT);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy window: %0d wrong cycles, want high for %0d cycles",
               name, busy_bad, LAT);
    end
    $display("op %s: %0d*%0d -> product=%0d ovf=%0b", name, a, b, product, ovf);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    index = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, product, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset state: got busy=%0b done=%0b product=%0d ovf=%0b, want all 0",
               busy, done, product, ovf);
    end
    $display("reset: busy=%0b done=%0b product=%0d ovf=%0b", busy, done, product, ovf);
  endtask

  task automatic test_basic();
    run_op(5, 7, "basic_5x7");
  endtask

  task automatic test_boundary();
    run_op(4095, 1, "max_x1");
    run_op(64, 64, "sat_64x64");
    run_op(0, 4095, "zero_index");
    run_op(4095, 0, "zero_div");
    run_op(4095, 4095, "sat_max");
    run_op(1, 4095, "one_x_max");
    run_op(63, 65, "fit_4095");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int a;
      int b;
      if (i % 2 == 0) begin
        a = $urandom_range(0, 4095);
        b = $urandom_range(0, 4095);
      end else begin
        a = $urandom_range(0, 90);
        b = $urandom_range(0, 90);
      end
      run_op(a, b, $sformatf("rand%0d", i));
    end
  endtask

  // A second start mid-calculation and another during the done cycle must
  // both be dropped without disturbing the result in flight.
  task automatic test_ignore_start();
    int done_cnt;
    @(negedge clk);
    index = 3; divisor = 100; start = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin index = 9; divisor = 9; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (k == LAT) begin
        n_checks++;
        if (product !== 12'd300 || ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_start result: got product=%0d ovf=%0b, want 300/0", product, ovf);
        end
        start = 1'b1;
      end
      if (k == LAT + 1) start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL ignore_start dropped: got busy=%0b done pulses=%0d, want busy=0 pulses=1",
               busy, done_cnt);
    end
    $display("ignore_start: product=%0d busy=%0b pulses=%0d", product, busy, done_cnt);
  endtask

  // start held high: one accept per W+2 cycles; operands scribbled mid-run
  // and replaced with the next request's values in the done cycle.
  task automatic test_back_to_back();
    int ops_a [3];
    int ops_b [3];
    logic [W-1:0] exp_p;
    logic         exp_o;
    int           bad_done;
    for (int i = 0; i < 3; i++) begin
      ops_a[i] = $urandom_range(0, 200);
      ops_b[i] = $urandom_range(0, 200);
    end
    bad_done = 0;
    @(negedge clk);
    index = W'(ops_a[0]); divisor = W'(ops_b[0]); start = 1'b1;
    for (int k = 1; k <= 3 * (W + 2); k++) begin
      @(negedge clk);
      if (done !== ((k % (W + 2)) == LAT)) bad_done++;
      if ((k % (W + 2)) == 5) begin
        index = W'($urandom); divisor = W'($urandom);
      end
      if ((k % (W + 2)) == LAT) begin
        ref_mul(ops_a[k / (W + 2)], ops_b[k / (W + 2)], exp_p, exp_o);
        n_checks++;
        if (product !== exp_p || ovf !== exp_o) begin
          n_fail++;
          $display("FAIL b2b op%0d: got product=%0d ovf=%0b, want %0d/%0b",
                   k / (W + 2), product, ovf, exp_p, exp_o);
        end
        $display("b2b op%0d: %0d*%0d -> product=%0d", k / (W + 2),
                 ops_a[k / (W + 2)], ops_b[k / (W + 2)], product);
        if (k / (W + 2) < 2) begin
          index   = W'(ops_a[k / (W + 2) + 1]);
          divisor = W'(ops_b[k / (W + 2) + 1]);
        end else begin
          start = 1'b0;
        end
      end
    end
    n_checks++;
    if (bad_done != 0) begin
      n_fail++;
      $display("FAIL b2b cadence: %0d cycles with wrong done, want pulse every %0d",
               bad_done, W + 2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    index = 50; divisor = 50; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, product, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: got busy=%0b done=%0b product=%0d ovf=%0b, want all 0",
               busy, done, product, ovf);
    end
    start = 1'b1; index = 7; divisor = 7;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_with_start: got busy=%0b, want 0", busy);
    end
    $display("reset_mid_calc: busy=%0b product=%0d", busy, product);
    run_op(2, 3, "after_reset_2x3");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_ff_multiplier

// File: doc/ff_multiplier.md
# ff_multiplier

Fixed-latency sequential multiplier: the inverse of the frame-count divider. Given a frame index and the per-frame step (divisor), it produces the position at which that frame begins (index × divisor), saturated to the 12-bit position range. It sits beside the divider in the frame-control path and lets control logic preload comparison thresholds or seek to an arbitrary frame.

## Interface
- `W`, default 12: operand and result width.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `index`  in  W: frame index (multiplicand); captured when `start` is accepted.
- `divisor`  in  W: per-frame step (multiplier); captured when `start` is accepted.
- `busy`  out  1: high from the cycle after acceptance through the DONE cycle.
- `done`  out  1: one-cycle pulse; `product` and `ovf` are valid from this cycle.
- `product`  out  W: `index*divisor`, or all-ones if it overflows. Held until the next acceptance.
- `ovf`  out  1: high when the true product exceeds 2^W−1. Held with `product`.

## Operation
- States:
  - IDLE → CALC on `start`. Operands are latched, the 2W-bit accumulator is cleared, and the bit counter is set to 0.
  - CALC: one shift-add step per cycle, LSB-first over the latched `divisor`. The latched index, zero-extended to 2W bits and shifted, is added when the divisor bit is 1. After W steps (counter = W−1) → DONE.
  - DONE: `product`/`ovf` registered from the accumulator, `done`=1 → IDLE.
- Arithmetic: 2W-bit accumulator, so there is no internal overflow. `ovf` = OR of accumulator bits [2W−1:W]. `product` = all-ones if `ovf`, otherwise accumulator[W−1:0].
- Zero operands take the full latency (no early exit). The result is 0 with `ovf`=0.
- `start` in CALC or DONE is ignored: no queueing, and the latched operands are unchanged.
- `index`/`divisor` changing after acceptance has no effect.
- `reset` takes priority over everything, including mid-CALC. It forces IDLE with all outputs 0 (`busy`, `done`, `product`, `ovf`).

## Timing
- Let T = the edge at which `start` is sampled in IDLE.
- `busy` rises after T and stays high for W+1 cycles (W CALC, 1 DONE).
- `done` is high in cycle T+W+1 only, which is 13 cycles after acceptance for W=12. `busy` falls one cycle later.
- `start` held high continuously yields back-to-back operations. The next acceptance occurs in the IDLE cycle after DONE, so throughput is one result per W+2 cycles.
- `start` asserted in the same cycle `done` is high is ignored, because the block is in DONE.
- `reset` in the same cycle as `start`: reset wins, and nothing is accepted.

## Structure
- Shared package `ff_pkg`:
  - `FF_W` = 12.
  - State enum `ff_mul_state_t` {IDLE, CALC, DONE}.
  - `FF_MAX` = all-ones constant, shared with the divider.
- Single flat module with one state register, a $clog2(W)-bit step counter, operand registers, and the accumulator. No sub-module is warranted.

## Test plan
- `index`=5, `divisor`=7, `start` pulse → `done` exactly 13 cycles later; `product`=35, `ovf`=0; `busy` high for 13 cycles.
- `index`=4095, `divisor`=1 → `product`=4095, `ovf`=0. Then `index`=64, `divisor`=64 → `product`=12'hFFF, `ovf`=1 (4096).
- `index`=0, `divisor`=4095 → `done` still at +13 cycles; `product`=0, `ovf`=0.
- Start 3×100. At cycle 5, drive `index`=9, `divisor`=9 and pulse `start` → result is 300; the second request is dropped. `start` held high → `done` pulses every 14 cycles.
- Start 50×50. Assert `reset` at cycle 6 → the next cycle shows `busy`=0, `done`=0, `product`=0, `ovf`=0. A new 2×3 request afterwards → 6 after 13 cycles.
